// File: rtl/led_status_ctrl.sv
// led_status_ctrl: priority status FSM and blink prescaler driving an active-low RGB LED
module led_status_ctrl #(
  parameter int CLK_FREQ_HZ = 24_000_000,
  parameter int BLINK_HZ    = 1,
  parameter int FLASH_MS    = 100
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       arm,
  input  logic       trig_pulse,
  input  logic       capture_done,
  input  logic       fault,
  input  logic       fault_clr,
  output logic [2:0] led,
  output logic [2:0] state_o
);
  localparam int HALF      = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int FLASH_CYC = (CLK_FREQ_HZ / 1000) * FLASH_MS;
  localparam int HW        = HALF > 1 ? $clog2(HALF) : 1;
  localparam int FW        = FLASH_CYC > 1 ? $clog2(FLASH_CYC) : 1;
  localparam logic [HW-1:0] HALF_MAX  = HW'(HALF - 1);
  localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_CYC - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, FLASH = 3'd2, DONE = 3'd3, FAULT = 3'd4} state_t;
  state_t          state, state_nx;
  logic [HW-1:0]   half_cnt;
  logic            phase;
  logic [FW-1:0]   flash_cnt, flash_nx;
  logic            fault_lat;
  logic [2:0]      led_nx;
  assign state_o = state;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      half_cnt  <= '0;
      phase     <= 1'b0;
      flash_cnt <= '0;
      fault_lat <= 1'b0;
      state     <= IDLE;
      led       <= 3'b111;
    end else begin
      half_cnt  <= half_cnt == HALF_MAX ? '0 : half_cnt + 1'b1;
      phase     <= half_cnt == HALF_MAX ? ~phase : phase;
      fault_lat <= fault | (fault_lat & ~fault_clr);
      flash_cnt <= flash_nx;
      state     <= state_nx;
      led       <= led_nx;
    end
  end
  always_comb begin
    state_nx = state;
    flash_nx = flash_cnt;
    if (fault_lat) state_nx = FAULT;
    else
      case (state)
        IDLE:  if (arm) state_nx = ARMED;
        ARMED: if (trig_pulse) begin
                 state_nx = FLASH;
                 flash_nx = FLASH_MAX;
               end else if (!arm) state_nx = IDLE;
        FLASH: if (trig_pulse) flash_nx = FLASH_MAX;
               else if (flash_cnt != '0) flash_nx = flash_cnt - 1'b1;
               else state_nx = capture_done ? DONE : arm ? ARMED : IDLE;
        DONE:  if (trig_pulse && arm) begin
                 state_nx = FLASH;
                 flash_nx = FLASH_MAX;
               end else if (!capture_done) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    led_nx = state == ARMED ? (phase ? 3'b011 : 3'b111) :
             state == FLASH ? 3'b000 :
             state == DONE  ? 3'b110 :
             state == FAULT ? (phase ? 3'b101 : 3'b111) : 3'b111;
  end
endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: scoreboard bench with directed per-cycle state vectors for led_status_ctrl
module tb_led_status_ctrl;
  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_FLASH = 3'd2, S_DONE = 3'd3, S_FAULT = 3'd4;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic arm = 1'b0, trig_pulse = 1'b0, capture_done = 1'b0, fault = 1'b0, fault_clr = 1'b0;
  logic [2:0] led, state_o;
  typedef struct {int id; logic [2:0] s; logic [2:0] l;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0, sid = 0;
  logic [2:0] prev_s = S_IDLE;
  int m_cnt;
  logic m_ph;
  led_status_ctrl #(.CLK_FREQ_HZ(1000), .BLINK_HZ(100), .FLASH_MS(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .arm(arm), .trig_pulse(trig_pulse),
    .capture_done(capture_done), .fault(fault), .fault_clr(fault_clr), .led(led), .state_o(state_o)
  );
  always #5 sys_clk = ~sys_clk;
  // reference blink phase: 5-cycle half periods from reset release
  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      m_cnt <= 0;
      m_ph  <= 1'b0;
    end else if (m_cnt == 4) begin
      m_cnt <= 0;
      m_ph  <= ~m_ph;
    end else m_cnt <= m_cnt + 1;
  function automatic logic [2:0] lmap(input logic [2:0] s, input logic ph);
    return s == S_ARMED ? (ph ? 3'b011 : 3'b111) : s == S_FLASH ? 3'b000 :
           s == S_DONE ? 3'b110 : s == S_FAULT ? (ph ? 3'b101 : 3'b111) : 3'b111;
  endfunction
  task automatic chk(input int id, input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %b expected %b", nm, id, act, exp);
  endtask
  // drive one cycle of inputs; queue the state expected after the edge and the led registered from the prior state
  task automatic step(input logic a, t, c, f, fc, input logic [2:0] s);
    logic [2:0] el;
    arm = a; trig_pulse = t; capture_done = c; fault = f; fault_clr = fc;
    el = lmap(prev_s, m_ph);
    @(posedge sys_clk);
    #1;
    exp_q.push_back('{sid, s, el});
    sid++;
    prev_s = s;
  endtask
  always @(negedge sys_clk)
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.id, "state_o", state_o, e.s);
      chk(e.id, "led", led, e.l);
    end
  initial begin
    repeat (2) @(posedge sys_clk);
    #1;
    chk(-1, "reset_state", state_o, S_IDLE);
    chk(-1, "reset_led", led, 3'b111);
    sys_rst_n = 1'b1;
    repeat (12) step(0, 0, 0, 0, 0, S_IDLE);
    step(0, 1, 0, 0, 0, S_IDLE);
    step(1, 0, 0, 0, 0, S_ARMED);
    repeat (14) step(1, 0, 0, 0, 0, S_ARMED);
    step(1, 1, 0, 0, 0, S_FLASH);
    repeat (3) step(1, 0, 0, 0, 0, S_FLASH);
    step(1, 0, 0, 0, 0, S_ARMED);
    repeat (2) step(1, 0, 0, 0, 0, S_ARMED);
    step(1, 1, 0, 0, 0, S_FLASH);
    step(1, 0, 0, 0, 0, S_FLASH);
    step(1, 1, 0, 0, 0, S_FLASH);
    repeat (3) step(1, 0, 0, 0, 0, S_FLASH);
    step(1, 0, 1, 0, 0, S_DONE);
    repeat (3) step(0, 0, 1, 0, 0, S_DONE);
    step(0, 0, 1, 1, 0, S_DONE);
    step(0, 0, 1, 0, 0, S_FAULT);
    repeat (12) step(0, 0, 0, 0, 0, S_FAULT);
    step(0, 0, 0, 1, 1, S_FAULT);
    repeat (3) step(0, 0, 0, 0, 0, S_FAULT);
    step(0, 0, 0, 0, 1, S_FAULT);
    repeat (2) step(0, 0, 0, 0, 0, S_IDLE);
    step(1, 0, 0, 0, 0, S_ARMED);
    step(0, 0, 0, 0, 0, S_IDLE);
    step(1, 0, 0, 0, 0, S_ARMED);
    step(1, 1, 0, 0, 0, S_FLASH);
    step(1, 0, 0, 0, 0, S_FLASH);
    @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk(sid, "async_rst_state", state_o, S_IDLE);
    chk(sid, "async_rst_led", led, 3'b111);
    #10;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
